// File: rtl/exmem_pipe_if.sv
// EX -> MEM pipeline register bus: EX-side handshake/payload in, MEM-side decoded payload out.
// The pipe attaches through the slave modport; the surrounding environment uses master.
`timescale 1ns/1ps
interface exmem_pipe_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    ctrl_mem_in;
   logic          ctrl_wb_in;
   logic [DW-1:0] alu_in;
   logic [DW-1:0] wdata_in;
   logic [RW-1:0] wreg_in;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic          mem_read_out;
   logic          mem_write_out;
   logic          wb_out;
   logic [DW-1:0] alu_out;
   logic [DW-1:0] wdata_out;
   logic [RW-1:0] wreg_out;

   modport slave (
      input  in_valid, ctrl_mem_in, ctrl_wb_in, alu_in, wdata_in, wreg_in, flush, out_ready,
      output in_ready, out_valid, mem_read_out, mem_write_out, wb_out, alu_out, wdata_out, wreg_out
   );

   modport master (
      output in_valid, ctrl_mem_in, ctrl_wb_in, alu_in, wdata_in, wreg_in, flush, out_ready,
      input  in_ready, out_valid, mem_read_out, mem_write_out, wb_out, alu_out, wdata_out, wreg_out
   );
endinterface

// File: rtl/exmem_pipe.sv
// EX/MEM pipeline stage: head + skid register so in_ready is a flop, independent of out_ready.
// Optional stall/bubble performance counters when EXMEM_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module exmem_pipe #(
   parameter int            DW      = 16,
   parameter int            RW      = 4,
   parameter logic [RW-1:0] NOP_REG = '1,
   parameter int            CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   exmem_pipe_if.slave      bus
`ifdef EXMEM_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

   state_e        state_q, state_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic          h_rd_q, h_rd_d;
   logic          h_wr_q, h_wr_d;
   logic          h_wb_q, h_wb_d;
   logic [DW-1:0] h_alu_q, h_alu_d;
   logic [DW-1:0] h_wdata_q, h_wdata_d;
   logic [RW-1:0] h_wreg_q, h_wreg_d;

   logic          s_rd_q, s_rd_d;
   logic          s_wr_q, s_wr_d;
   logic          s_wb_q, s_wb_d;
   logic [DW-1:0] s_alu_q, s_alu_d;
   logic [DW-1:0] s_wdata_q, s_wdata_d;
   logic [RW-1:0] s_wreg_q, s_wreg_d;

   logic          accept, xfer;
   logic          in_rd, in_wr;

   assign accept = bus.in_valid && in_ready_q;
   assign xfer   = out_valid_q && bus.out_ready;
   assign in_rd  = (bus.ctrl_mem_in == 2'b01);
   assign in_wr  = (bus.ctrl_mem_in == 2'b10);

   // Head control flops are zeroed and wreg forced to NOP_REG whenever H empties,
   // so outputs are plain flop copies; alu/wdata deliberately keep their last value.
   always_comb begin
      state_d   = state_q;
      h_rd_d    = h_rd_q;
      h_wr_d    = h_wr_q;
      h_wb_d    = h_wb_q;
      h_alu_d   = h_alu_q;
      h_wdata_d = h_wdata_q;
      h_wreg_d  = h_wreg_q;
      s_rd_d    = s_rd_q;
      s_wr_d    = s_wr_q;
      s_wb_d    = s_wb_q;
      s_alu_d   = s_alu_q;
      s_wdata_d = s_wdata_q;
      s_wreg_d  = s_wreg_q;

      if (bus.flush) begin
         state_d  = ST_EMPTY;
         h_rd_d   = 1'b0;
         h_wr_d   = 1'b0;
         h_wb_d   = 1'b0;
         h_wreg_d = NOP_REG;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d   = ST_ONE;
                  h_rd_d    = in_rd;
                  h_wr_d    = in_wr;
                  h_wb_d    = bus.ctrl_wb_in;
                  h_alu_d   = bus.alu_in;
                  h_wdata_d = bus.wdata_in;
                  h_wreg_d  = bus.wreg_in;
               end
            end
            ST_ONE: begin
               if (accept && xfer) begin
                  h_rd_d    = in_rd;
                  h_wr_d    = in_wr;
                  h_wb_d    = bus.ctrl_wb_in;
                  h_alu_d   = bus.alu_in;
                  h_wdata_d = bus.wdata_in;
                  h_wreg_d  = bus.wreg_in;
               end else if (accept) begin
                  state_d   = ST_TWO;
                  s_rd_d    = in_rd;
                  s_wr_d    = in_wr;
                  s_wb_d    = bus.ctrl_wb_in;
                  s_alu_d   = bus.alu_in;
                  s_wdata_d = bus.wdata_in;
                  s_wreg_d  = bus.wreg_in;
               end else if (xfer) begin
                  state_d  = ST_EMPTY;
                  h_rd_d   = 1'b0;
                  h_wr_d   = 1'b0;
                  h_wb_d   = 1'b0;
                  h_wreg_d = NOP_REG;
               end
            end
            ST_TWO: begin
               if (xfer) begin
                  state_d   = ST_ONE;
                  h_rd_d    = s_rd_q;
                  h_wr_d    = s_wr_q;
                  h_wb_d    = s_wb_q;
                  h_alu_d   = s_alu_q;
                  h_wdata_d = s_wdata_q;
                  h_wreg_d  = s_wreg_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end

      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         h_rd_q      <= 1'b0;
         h_wr_q      <= 1'b0;
         h_wb_q      <= 1'b0;
         h_alu_q     <= '0;
         h_wdata_q   <= '0;
         h_wreg_q    <= NOP_REG;
         s_rd_q      <= 1'b0;
         s_wr_q      <= 1'b0;
         s_wb_q      <= 1'b0;
         s_alu_q     <= '0;
         s_wdata_q   <= '0;
         s_wreg_q    <= NOP_REG;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         h_rd_q      <= h_rd_d;
         h_wr_q      <= h_wr_d;
         h_wb_q      <= h_wb_d;
         h_alu_q     <= h_alu_d;
         h_wdata_q   <= h_wdata_d;
         h_wreg_q    <= h_wreg_d;
         s_rd_q      <= s_rd_d;
         s_wr_q      <= s_wr_d;
         s_wb_q      <= s_wb_d;
         s_alu_q     <= s_alu_d;
         s_wdata_q   <= s_wdata_d;
         s_wreg_q    <= s_wreg_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.mem_read_out  = h_rd_q;
   assign bus.mem_write_out = h_wr_q;
   assign bus.wb_out        = h_wb_q;
   assign bus.alu_out       = h_alu_q;
   assign bus.wdata_out     = h_wdata_q;
   assign bus.wreg_out      = h_wreg_q;

`ifdef EXMEM_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Both counters saturate at all-ones and only reset clears them.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (!out_valid_q && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_exmem_pipe.sv
// Self-checking bench for exmem_pipe: directed scenarios then random traffic against a queue model.
`timescale 1ns/1ps
module tb_exmem_pipe;
  localparam int DW = 16;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exmem_pipe_if #(.DW(DW), .RW(RW)) bus ();

`ifdef EXMEM_PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic [1:0]  stall_cnt2, bubble_cnt2;
  exmem_pipe_if #(.DW(DW), .RW(RW)) bus2 ();
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.ctrl_mem_in = bus.ctrl_mem_in;
  assign bus2.ctrl_wb_in  = bus.ctrl_wb_in;
  assign bus2.alu_in      = bus.alu_in;
  assign bus2.wdata_in    = bus.wdata_in;
  assign bus2.wreg_in     = bus.wreg_in;
  assign bus2.flush       = bus.flush;
  assign bus2.out_ready   = bus.out_ready;

  exmem_pipe #(.DW(DW), .RW(RW), .NOP_REG(4'hF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));
  exmem_pipe #(.DW(DW), .RW(RW), .NOP_REG(4'hF), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2));
`else
  exmem_pipe #(.DW(DW), .RW(RW), .NOP_REG(4'hF), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  typedef struct {
    logic [1:0]    mem;
    logic          wb;
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic [RW-1:0] wreg;
  } ent_t;

  ent_t q[$];
  logic [DW-1:0] last_alu, last_wd;
  int st16, bu16, st2, bu2;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check current outputs against the model, then advance model and DUT one clock.
  task automatic tick();
    logic ev, acc, xf;
    ent_t e, h;
    ev = (q.size() > 0);
    chk("in_ready",  bus.in_ready,  q.size() < 2);
    chk("out_valid", bus.out_valid, ev);
    if (ev) begin
      h = q[0];
      last_alu = h.alu;
      last_wd  = h.wdata;
      chk("mem_read",  bus.mem_read_out,  h.mem == 2'b01);
      chk("mem_write", bus.mem_write_out, h.mem == 2'b10);
      chk("wb",        bus.wb_out,        h.wb);
      chk("wreg",      bus.wreg_out,      h.wreg);
    end else begin
      chk("mem_read",  bus.mem_read_out,  0);
      chk("mem_write", bus.mem_write_out, 0);
      chk("wb",        bus.wb_out,        0);
      chk("wreg",      bus.wreg_out,      4'hF);
    end
    chk("alu_out",   bus.alu_out,   last_alu);
    chk("wdata_out", bus.wdata_out, last_wd);
`ifdef EXMEM_PERF_CNT_EN
    chk("stall_cnt",   stall_cnt,   st16);
    chk("bubble_cnt",  bubble_cnt,  bu16);
    chk("stall_cnt2",  stall_cnt2,  st2);
    chk("bubble_cnt2", bubble_cnt2, bu2);
`endif
    acc = bus.in_valid && (q.size() < 2);
    xf  = ev && bus.out_ready;
    if (rst) begin
      st16 = 0; bu16 = 0; st2 = 0; bu2 = 0;
    end else begin
      if (ev && !bus.out_ready) begin
        if (st16 < 65535) st16++;
        if (st2 < 3) st2++;
      end
      if (!ev) begin
        if (bu16 < 65535) bu16++;
        if (bu2 < 3) bu2++;
      end
    end
    if (rst) begin
      q.delete();
      last_alu = '0;
      last_wd  = '0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (acc) begin
        e.mem = bus.ctrl_mem_in; e.wb = bus.ctrl_wb_in; e.alu = bus.alu_in;
        e.wdata = bus.wdata_in; e.wreg = bus.wreg_in;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic wb,
                       input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [RW-1:0] r);
    bus.in_valid = v; bus.ctrl_mem_in = m; bus.ctrl_wb_in = wb;
    bus.alu_in = a; bus.wdata_in = d; bus.wreg_in = r;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0);
    last_alu = '0; last_wd = '0;
    st16 = 0; bu16 = 0; st2 = 0; bu2 = 0;
    @(posedge clk);
    #1;

    // Reset with in_valid high: stage must come up empty.
    drive(1'b1, 2'b01, 1'b1, 16'h1234, 16'h5678, 4'h2);
    tick();
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0);
    tick();

    // Streaming loads with MEM always ready.
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b01, 1'b1, 16'h0010, 16'h0001, 4'h1); tick();
    drive(1'b1, 2'b01, 1'b1, 16'h0020, 16'h0002, 4'h2); tick();
    drive(1'b1, 2'b01, 1'b1, 16'h0030, 16'h0003, 4'h3); tick();
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0); tick(); tick();

    // Backpressure: A, B fill the stage, C is held off until MEM drains.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 16'hAAAA, 16'h1111, 4'hA); tick();
    drive(1'b1, 2'b10, 1'b0, 16'hBBBB, 16'h2222, 4'hB); tick();
    drive(1'b1, 2'b10, 1'b0, 16'hCCCC, 16'h3333, 4'hC); tick(); tick();
    bus.out_ready = 1'b1; tick();
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0); tick(); tick(); tick();

    // Flush while full with in_valid high.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b1, 16'h0101, 16'h0202, 4'h4); tick();
    drive(1'b1, 2'b01, 1'b1, 16'h0303, 16'h0404, 4'h5); tick();
    bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0); tick();

    // ctrl_mem 11 decodes to no memory access but keeps write-back.
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b11, 1'b1, 16'h0042, 16'h0043, 4'h3); tick();
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0); tick();

    // Fresh reset, one entry held for six stall cycles (saturates the 2-bit counter).
    rst = 1'b1; tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b01, 1'b0, 16'h0777, 16'h0888, 4'h6); tick();
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0);
    repeat (6) tick();
    bus.out_ready = 1'b1; tick(); tick();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 2'($urandom), 1'($urandom),
            DW'($urandom), DW'($urandom), RW'($urandom));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0; bus.flush = 1'b0;
    drive(1'b0, 2'b00, 1'b0, '0, '0, '0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
